// File: rtl/pts_tx_pkg.sv
// Shared types and constants for the parallel-to-serial transmit controller.
// The serial line idles high, so the "empty" parallel word is all ones.
package pts_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } pts_tx_state_t;

    localparam int MAX_DATA_BITS = 32;

    localparam logic [MAX_DATA_BITS-1:0] IDLE_LINE = '1;

endpackage

// File: rtl/pts_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0 while enabled, then reloads.
// rollover marks the last clock of each bit period.
module pts_bit_timer
    import pts_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= RELOAD;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= (count == '0) ? RELOAD : count - 1'b1;
        end
    end

    assign rollover = enable && (count == '0);

endmodule

// File: rtl/pts_tx_ctrl.sv
// Transmit controller driving an external parallel-to-serial shifter (load/shift strobes).
// Optional abort input enabled by defining PTS_TX_CTRL_ABORT_EN.
module pts_tx_ctrl
    import pts_tx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int SHIFT_MSB    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
`ifdef PTS_TX_CTRL_ABORT_EN
    input  logic                 tx_abort,
`endif
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] pts_data,
    output logic                 load_enable,
    output logic                 shift_enable,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] IDLE_WORD = IDLE_LINE[DATA_BITS-1:0];

    // SHIFT_MSB belongs to the shifter; it is only range-checked here.
    if (DATA_BITS < 2 || DATA_BITS > MAX_DATA_BITS ||
        CLKS_PER_BIT < 1 || CLKS_PER_BIT > 1024 ||
        (SHIFT_MSB != 0 && SHIFT_MSB != 1)) begin : g_bad_param
        $error("pts_tx_ctrl: parameter out of legal range");
    end

    pts_tx_state_t    state;
    logic [CNT_W-1:0] bit_cnt;
    logic             timer_run;
    logic             rollover;
`ifdef PTS_TX_CTRL_ABORT_EN
    logic             abort_pend;
`endif

    // Timer sits at reload outside LOAD/SHIFT so cycle L starts a fresh bit period.
    assign timer_run = (state == LOAD) || (state == SHIFT);

    pts_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (!timer_run),
        .enable  (timer_run),
        .rollover(rollover)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            pts_data     <= IDLE_WORD;
            tx_ready     <= 1'b1;
            load_enable  <= 1'b0;
            shift_enable <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
`ifdef PTS_TX_CTRL_ABORT_EN
            abort_pend   <= 1'b0;
`endif
        end else begin
            load_enable  <= 1'b0;
            shift_enable <= 1'b0;
            tx_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        pts_data    <= tx_data;
                        bit_cnt     <= '0;
                        load_enable <= 1'b1;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD, SHIFT: begin
`ifdef PTS_TX_CTRL_ABORT_EN
                    if (abort_pend) begin
                        abort_pend <= 1'b0;
                        tx_ready   <= 1'b1;
                        tx_busy    <= 1'b0;
                        state      <= IDLE;
                    end else if (tx_abort) begin
                        // Reload the idle line into the shifter, then drop back to IDLE.
                        pts_data    <= IDLE_WORD;
                        load_enable <= 1'b1;
                        abort_pend  <= 1'b1;
                        state       <= LOAD;
                    end else
`endif
                    if (rollover) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            bit_cnt      <= bit_cnt + 1'b1;
                            shift_enable <= 1'b1;
                            state        <= SHIFT;
                        end
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Directed bench for pts_tx_ctrl: one DUT at CLKS_PER_BIT=4, one at CLKS_PER_BIT=1.
// Cycle c counts rising edges after the handshake edge; cycle 1 is L.
module tb_pts_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready, a_load, a_shift, a_busy, a_done;
    logic       b_ready, b_load, b_shift, b_busy, b_done;
    logic [7:0] a_pts, b_pts;
`ifdef PTS_TX_CTRL_ABORT_EN
    logic       a_abort, b_abort;
`endif

    int total = 0;
    int bad   = 0;

    pts_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .SHIFT_MSB(1)) dut_a (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_valid    (a_valid),
        .tx_data     (a_data),
`ifdef PTS_TX_CTRL_ABORT_EN
        .tx_abort    (a_abort),
`endif
        .tx_ready    (a_ready),
        .pts_data    (a_pts),
        .load_enable (a_load),
        .shift_enable(a_shift),
        .tx_busy     (a_busy),
        .tx_done     (a_done)
    );

    pts_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(1), .SHIFT_MSB(0)) dut_b (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_valid    (b_valid),
        .tx_data     (b_data),
`ifdef PTS_TX_CTRL_ABORT_EN
        .tx_abort    (b_abort),
`endif
        .tx_ready    (b_ready),
        .pts_data    (b_pts),
        .load_enable (b_load),
        .shift_enable(b_shift),
        .tx_busy     (b_busy),
        .tx_done     (b_done)
    );

    // {ready, load, shift, busy, done}
    function automatic logic [4:0] a_flags();
        return {a_ready, a_load, a_shift, a_busy, a_done};
    endfunction

    function automatic logic [4:0] b_flags();
        return {b_ready, b_load, b_shift, b_busy, b_done};
    endfunction

    // Expected flags for cycle c of a single word (no further handshake).
    function automatic logic [4:0] exp_flags(int c, int cpb, int bits);
        logic ld, sh, dn, bz;
        ld = (c == 1);
        sh = (c >= 2) && (c <= 1 + (bits - 1) * cpb) && (((c - 1) % cpb) == 0);
        dn = (c == 1 + bits * cpb);
        bz = (c >= 1) && (c <= 1 + bits * cpb);
        return {!bz, ld, sh, bz, dn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;
`ifdef PTS_TX_CTRL_ABORT_EN
        a_abort = 1'b0;
        b_abort = 1'b0;
`endif
        #12;
        total++;
        if (a_flags() !== 5'b10000 || a_pts !== 8'hFF) begin
            bad++;
            $display("FAIL reset_a flags=%b pts=%h want flags=10000 pts=ff", a_flags(), a_pts);
        end
        total++;
        if (b_flags() !== 5'b10000 || b_pts !== 8'hFF) begin
            bad++;
            $display("FAIL reset_b flags=%b pts=%h want flags=10000 pts=ff", b_flags(), b_pts);
        end
        a_valid = 1'b1;
        a_data  = 8'h12;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (a_flags() !== 5'b10000 || a_pts !== 8'hFF) begin
                bad++;
                $display("FAIL reset_hold flags=%b pts=%h want flags=10000 pts=ff", a_flags(), a_pts);
            end
        end
        a_valid = 1'b0;
        n_rst   = 1'b1;
    endtask

    task automatic test_basic();
        a_valid = 1'b1;
        a_data  = 8'hA5;
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready0 got=%b want=1", a_ready);
        end
        for (int c = 1; c <= 35; c++) begin
            step();
            if (c == 1) a_valid = 1'b0;
            total++;
            if (a_flags() !== exp_flags(c, 4, 8) || a_pts !== 8'hA5) begin
                bad++;
                $display("FAIL basic c=%0d flags=%b pts=%h want flags=%b pts=a5",
                         c, a_flags(), a_pts, exp_flags(c, 4, 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ef;
        logic [7:0] ep;
        a_valid = 1'b1;
        a_data  = 8'h3C;
        for (int c = 1; c <= 68; c++) begin
            step();
            if (c == 1)  a_data  = 8'hC3;
            if (c == 35) a_valid = 1'b0;
            ef = (c <= 34) ? exp_flags(c, 4, 8) : exp_flags(c - 34, 4, 8);
            ep = (c <= 34) ? 8'h3C : 8'hC3;
            total++;
            if (a_flags() !== ef || a_pts !== ep) begin
                bad++;
                $display("FAIL b2b c=%0d flags=%b pts=%h want flags=%b pts=%h",
                         c, a_flags(), a_pts, ef, ep);
            end
        end
    endtask

    task automatic test_cpb1();
        b_valid = 1'b1;
        b_data  = 8'hFF;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) b_valid = 1'b0;
            total++;
            if (b_flags() !== exp_flags(c, 1, 8) || b_pts !== 8'hFF) begin
                bad++;
                $display("FAIL cpb1 c=%0d flags=%b pts=%h want flags=%b pts=ff",
                         c, b_flags(), b_pts, exp_flags(c, 1, 8));
            end
        end
    endtask

    task automatic test_hold_data();
        a_valid = 1'b1;
        a_data  = 8'h5A;
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c == 1) a_valid = 1'b0;
            if (c == 6) begin
                a_data  = 8'h00;
                a_valid = 1'b1;
            end
            if (c == 30) a_valid = 1'b0;
            total++;
            if (a_flags() !== exp_flags(c, 4, 8) || a_pts !== 8'h5A) begin
                bad++;
                $display("FAIL hold c=%0d flags=%b pts=%h want flags=%b pts=5a",
                         c, a_flags(), a_pts, exp_flags(c, 4, 8));
            end
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1;
        a_data  = 8'h96;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) a_valid = 1'b0;
            total++;
            if (a_flags() !== exp_flags(c, 4, 8) || a_pts !== 8'h96) begin
                bad++;
                $display("FAIL rstmid_pre c=%0d flags=%b pts=%h want flags=%b pts=96",
                         c, a_flags(), a_pts, exp_flags(c, 4, 8));
            end
        end
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if (a_flags() !== 5'b10000 || a_pts !== 8'hFF) begin
            bad++;
            $display("FAIL rstmid_async flags=%b pts=%h want flags=10000 pts=ff", a_flags(), a_pts);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (a_flags() !== 5'b10000 || a_pts !== 8'hFF) begin
                bad++;
                $display("FAIL rstmid_hold i=%0d flags=%b pts=%h want flags=10000 pts=ff",
                         i, a_flags(), a_pts);
            end
        end
        n_rst   = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'h11;
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c == 1) a_valid = 1'b0;
            total++;
            if (a_flags() !== exp_flags(c, 4, 8) || a_pts !== 8'h11) begin
                bad++;
                $display("FAIL rstmid_post c=%0d flags=%b pts=%h want flags=%b pts=11",
                         c, a_flags(), a_pts, exp_flags(c, 4, 8));
            end
        end
    endtask

`ifdef PTS_TX_CTRL_ABORT_EN
    task automatic test_abort();
        a_valid = 1'b1;
        a_data  = 8'h77;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) a_valid = 1'b0;
            total++;
            if (a_flags() !== exp_flags(c, 4, 8) || a_pts !== 8'h77) begin
                bad++;
                $display("FAIL abort_pre c=%0d flags=%b pts=%h want flags=%b pts=77",
                         c, a_flags(), a_pts, exp_flags(c, 4, 8));
            end
        end
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        total++;
        if (a_flags() !== 5'b01010 || a_pts !== 8'hFF) begin
            bad++;
            $display("FAIL abort_load flags=%b pts=%h want flags=01010 pts=ff", a_flags(), a_pts);
        end
        for (int c = 12; c <= 40; c++) begin
            step();
            total++;
            if (a_flags() !== 5'b10000 || a_pts !== 8'hFF) begin
                bad++;
                $display("FAIL abort_idle c=%0d flags=%b pts=%h want flags=10000 pts=ff",
                         c, a_flags(), a_pts);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_cpb1();
        test_hold_data();
        test_reset_mid();
`ifdef PTS_TX_CTRL_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pts_tx_ctrl.md
PTS_TX_CTRL -- requirements
Module: pts_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: number of data bits per word, legal range 2..32.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit period, legal range 1..1024.
REQ-003 The block SHALL have parameter SHIFT_MSB, default 1: 1 = MSB first, 0 = LSB first; it is passed through unchanged as the shifter's direction setting.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: the requester has a word on tx_data.
REQ-007 The block SHALL have port tx_data, input, DATA_BITS bits: the word to send.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port pts_data, output, DATA_BITS bits: the registered word presented to the shifter's parallel input.
REQ-010 The block SHALL have port load_enable, output, 1 bit: one-cycle strobe telling the shifter to load pts_data.
REQ-011 The block SHALL have port shift_enable, output, 1 bit: one-cycle strobe telling the shifter to shift.
REQ-012 The block SHALL have port tx_busy, output, 1 bit: a word is in flight.
REQ-013 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse when the last bit period ends.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, SHIFT and DONE.
REQ-015 tx_ready SHALL equal 1 only in IDLE; a handshake is tx_valid=1 and tx_ready=1 on the same rising edge.
REQ-016 On a handshake, the block SHALL register tx_data into pts_data and go to LOAD.
REQ-017 In LOAD, load_enable SHALL be 1 for exactly one cycle, called cycle L; the block then goes to SHIFT.
REQ-018 In SHIFT, shift_enable SHALL pulse for one cycle at cycles L+i*CLKS_PER_BIT, for i = 1..DATA_BITS-1 only (exactly DATA_BITS-1 pulses).
REQ-019 tx_done SHALL be 1 for exactly one cycle, at cycle L+DATA_BITS*CLKS_PER_BIT; during that cycle the block is in DONE and then returns to IDLE.
REQ-020 tx_busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-021 load_enable and shift_enable SHALL never be 1 in the same cycle.
REQ-022 The bit timer SHALL count CLKS_PER_BIT-1 down to 0 and reload; the bit counter SHALL be $clog2(DATA_BITS+1) bits wide and never wrap mid-word.
REQ-023 With CLKS_PER_BIT=1, shift_enable SHALL be 1 on the DATA_BITS-1 consecutive cycles after L.
REQ-024 tx_valid and tx_data changes outside IDLE SHALL be ignored, and pts_data SHALL stay stable until the next handshake.
REQ-025 Back-to-back words SHALL have a minimum of one IDLE cycle between the tx_done of one word and the LOAD of the next.

Reset
REQ-026 While n_rst=0, the block SHALL be in IDLE with tx_ready=1, pts_data all ones, and load_enable, shift_enable, tx_busy and tx_done all 0.
REQ-027 Reset asserted mid-word SHALL abandon the word immediately, asynchronously, with no tx_done pulse.
REQ-028 After reset is released, the first handshake SHALL be accepted on the first rising edge.

Configuration
REQ-029 The macro PTS_TX_CTRL_ABORT_EN SHALL control an abort feature.
REQ-030 When PTS_TX_CTRL_ABORT_EN is defined, the block SHALL have an input tx_abort, 1 bit.
REQ-031 When tx_abort=1 in LOAD or SHIFT, the block SHALL, on the next cycle, set pts_data to all ones, pulse load_enable, and enter IDLE with no tx_done pulse; tx_abort SHALL take priority over a shift_enable due in the same cycle.
REQ-032 When PTS_TX_CTRL_ABORT_EN is undefined, the tx_abort port and its logic SHALL be absent, and behaviour SHALL be REQ-014..REQ-025 only.

Structure
REQ-033 The package pts_tx_pkg SHALL hold the state enum type pts_tx_state_t (IDLE, LOAD, SHIFT, DONE) and the constant IDLE_LINE = all ones.
REQ-034 The bit-period timer SHALL be the sub-module pts_bit_timer: ports clk, n_rst, clear, enable, rollover; parameter CLKS_PER_BIT.
REQ-035 The block SHALL contain no shifter itself; it drives an external parallel-to-serial shifter only.

Verification
REQ-036 Bench: DATA_BITS=8, CLKS_PER_BIT=4, handshake 0xA5 at cycle 0 -> load_enable at cycle 1; shift_enable at cycles 5, 9, ..., 29 (7 pulses); tx_done at cycle 33; tx_ready=1 at cycle 34.
REQ-037 Bench: tx_valid held high with 0x3C then 0xC3 -> 2nd handshake no earlier than 1 cycle after the 1st tx_done; pts_data=0x3C throughout word 1.
REQ-038 Bench: CLKS_PER_BIT=1, data 0xFF -> shift_enable high on cycles 2..8, tx_done on cycle 9.
REQ-039 Bench: n_rst pulled low at cycle 12 of a word -> all outputs take reset values within the same cycle, no tx_done; next handshake accepted after release.
REQ-040 Bench: tx_data changed to 0x00 during SHIFT of 0x5A -> pts_data stays 0x5A.
REQ-041 Bench (PTS_TX_CTRL_ABORT_EN defined): tx_abort at cycle 10 -> load_enable with pts_data=0xFF at cycle 11, IDLE at cycle 12, no tx_done.
